// File: rtl/tlv5618_spi_receiver.sv
// Receive-side model of the TLV5618 serial port: oversamples CS/SCLK/DIN, assembles
// 16-bit frames and maintains the DAC A, DAC B and double-buffer latches.
module tlv5618_spi_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DAC_cs_n,
    input  logic        DAC_sclk,
    input  logic        DAC_din,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        frame_err,
    output logic        rsvd_err,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_buf,
    output logic        speed,
    output logic        pwr_down
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_chain;
    logic                   cs_prev, sclk_prev;
    logic                   cs_s, sclk_s, din_sync;
    logic                   cs_fall, cs_rise, sclk_fall;
    logic [15:0]            shreg;
    logic [4:0]             bitcnt;

    // CS and SCLK idle high so that reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            din_chain <= '0;
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage take the previous
            // stage's old value, which is what makes this a shift chain.
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], DAC_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], DAC_sclk};
            din_chain <= {din_chain[SYNC_STAGES-2:0], DAC_din};
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_sync  = din_chain[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bitcnt     <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            rsvd_err   <= 1'b0;
            dac_a      <= '0;
            dac_b      <= '0;
            dac_buf    <= '0;
            speed      <= 1'b0;
            pwr_down   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            rsvd_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shreg  <= '0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    // A CS rise in the same cycle ends the frame before this bit.
                    if (sclk_fall && !cs_rise) begin
                        shreg <= {shreg[14:0], din_sync};
                        if (bitcnt != 5'd17) bitcnt <= bitcnt + 5'd1;
                    end
                end
                COMMIT: begin
                    if (bitcnt != 5'd16) begin
                        frame_err <= 1'b1;
                    end else begin
                        word       <= shreg;
                        word_valid <= 1'b1;
                        case ({shreg[15], shreg[12]})
                            2'b00: begin
                                dac_b   <= shreg[11:0];
                                dac_buf <= shreg[11:0];
                            end
                            2'b01: dac_buf <= shreg[11:0];
                            2'b10: begin
                                dac_a <= shreg[11:0];
                                dac_b <= dac_buf;
                            end
                            default: rsvd_err <= 1'b1;
                        endcase
                        if ({shreg[15], shreg[12]} != 2'b11) begin
                            speed    <= shreg[14];
                            pwr_down <= shreg[13];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlv5618_spi_receiver.sv
// Directed bench for tlv5618_spi_receiver: drives TLV5618-style frames and checks
// decoded latches and pulse counts against hand-computed values.
module tb_tlv5618_spi_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        DAC_cs_n = 1'b1;
    logic        DAC_sclk = 1'b0;
    logic        DAC_din = 1'b0;
    logic [15:0] word;
    logic        word_valid, frame_err, rsvd_err, speed, pwr_down;
    logic [11:0] dac_a, dac_b, dac_buf;

    int checks = 0;
    int errors = 0;
    int n_wv = 0, n_fe = 0, n_re = 0;
    int s_wv, s_fe, s_re;

    tlv5618_spi_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .DAC_cs_n(DAC_cs_n), .DAC_sclk(DAC_sclk), .DAC_din(DAC_din),
        .word(word), .word_valid(word_valid), .frame_err(frame_err), .rsvd_err(rsvd_err),
        .dac_a(dac_a), .dac_b(dac_b), .dac_buf(dac_buf),
        .speed(speed), .pwr_down(pwr_down)
    );

    always #5 clk = ~clk;

    // Pulse counters: a one-cycle pulse adds exactly one.
    always @(posedge clk) begin
        if (word_valid) n_wv++;
        if (frame_err)  n_fe++;
        if (rsvd_err)   n_re++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            DAC_sclk = 1'b1;
            DAC_din  = (i < 16) ? data[15-i] : 1'b0;
            wait_clk(4);
            DAC_sclk = 1'b0;
            wait_clk(4);
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits);
        s_wv = n_wv; s_fe = n_fe; s_re = n_re;
        DAC_cs_n = 1'b0;
        wait_clk(4);
        send_bits(data, nbits);
        DAC_cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic check_pulses(input string tag, input int wv, input int fe, input int re);
        check({tag, "_word_valid"}, n_wv - s_wv, wv);
        check({tag, "_frame_err"},  n_fe - s_fe, fe);
        check({tag, "_rsvd_err"},   n_re - s_re, re);
    endtask

    task automatic check_latches(input string tag, input logic [11:0] a, input logic [11:0] b,
                                 input logic [11:0] buff, input logic spd, input logic pwr);
        check({tag, "_dac_a"},    dac_a, a);
        check({tag, "_dac_b"},    dac_b, b);
        check({tag, "_dac_buf"},  dac_buf, buff);
        check({tag, "_speed"},    speed, spd);
        check({tag, "_pwr_down"}, pwr_down, pwr);
    endtask

    initial begin
        // Reset with idle pins.
        wait_clk(5);
        check("rst_word", word, 16'h0000);
        check_latches("rst", 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
        s_wv = n_wv; s_fe = n_fe; s_re = n_re;
        rst_n = 1'b1;
        wait_clk(10);
        check_pulses("post_rst", 0, 0, 0);

        // R1R0=01: buffer only, SPD=1.
        send_frame(16'h57D0, 16);
        check_pulses("f57d0", 1, 0, 0);
        check("f57d0_word", word, 16'h57D0);
        check_latches("f57d0", 12'h000, 12'h000, 12'h7D0, 1'b1, 1'b0);

        // R1R0=10: DAC A loads, DAC B takes old buffer.
        send_frame(16'hC3E8, 16);
        check_pulses("fc3e8", 1, 0, 0);
        check("fc3e8_word", word, 16'hC3E8);
        check_latches("fc3e8", 12'h3E8, 12'h7D0, 12'h7D0, 1'b1, 1'b0);

        // R1R0=00: DAC B and buffer, PWR=1, SPD=0.
        send_frame(16'h2ABC, 16);
        check_pulses("f2abc", 1, 0, 0);
        check_latches("f2abc", 12'h3E8, 12'hABC, 12'hABC, 1'b0, 1'b1);

        // R1R0=11: reserved, word updates but nothing else.
        send_frame(16'hD123, 16);
        check_pulses("fd123", 1, 0, 1);
        check("fd123_word", word, 16'hD123);
        check_latches("fd123", 12'h3E8, 12'hABC, 12'hABC, 1'b0, 1'b1);

        // Short and long frames.
        send_frame(16'h0555, 15);
        check_pulses("short", 0, 1, 0);
        check("short_word", word, 16'hD123);
        check_latches("short", 12'h3E8, 12'hABC, 12'hABC, 1'b0, 1'b1);

        send_frame(16'h0555, 17);
        check_pulses("long", 0, 1, 0);
        check("long_word", word, 16'hD123);
        check_latches("long", 12'h3E8, 12'hABC, 12'hABC, 1'b0, 1'b1);

        send_frame(16'h0555, 16);
        check_pulses("f0555", 1, 0, 0);
        check("f0555_word", word, 16'h0555);
        check_latches("f0555", 12'h3E8, 12'h555, 12'h555, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        DAC_cs_n = 1'b0;
        wait_clk(4);
        send_bits(16'hA5A5, 8);
        rst_n = 1'b0;
        #1;
        check("midrst_word", word, 16'h0000);
        check_latches("midrst", 12'h000, 12'h000, 12'h000, 1'b0, 1'b0);
        DAC_cs_n = 1'b1;
        DAC_sclk = 1'b0;
        wait_clk(3);
        s_wv = n_wv; s_fe = n_fe; s_re = n_re;
        rst_n = 1'b1;
        wait_clk(10);
        check_pulses("midrst_release", 0, 0, 0);

        send_frame(16'h8FFF, 16);
        check_pulses("f8fff", 1, 0, 0);
        check("f8fff_word", word, 16'h8FFF);
        check_latches("f8fff", 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlv5618_spi_receiver.md
# tlv5618_spi_receiver

Synthesizable receive-side model of the TLV5618 dual 12-bit DAC serial port. It oversamples `DAC_cs_n`, `DAC_sclk` and `DAC_din` with the system clock, assembles 16-bit frames, and decodes the TLV5618 control nibble. It maintains the DAC A, DAC B and double-buffer latches exactly as the device does. It sits on the far side of the DAC driver in loopback benches and on-chip self-test, so the driver's output can be checked against decoded register values.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `DAC_cs_n`, `DAC_sclk` and `DAC_din`. Legal range is 2..4.
- `clk` input 1: system clock. Rising edge only.
- `rst_n` input 1: reset, asynchronous, active-low.
- `DAC_cs_n` input 1: frame select, active-low. Asynchronous to `clk`.
- `DAC_sclk` input 1: serial clock. Asynchronous to `clk`. Its high and low phases are each ≥ 2 `clk` periods.
- `DAC_din` input 1: serial data, MSB first.
- `word` output 16: last completed 16-bit frame.
- `word_valid` output 1: one-cycle pulse when `word` updates.
- `frame_err` output 1: one-cycle pulse on a bad frame length.
- `rsvd_err` output 1: one-cycle pulse on a frame with reserved code R1R0=11.
- `dac_a` output 12: DAC A latch.
- `dac_b` output 12: DAC B latch.
- `dac_buf` output 12: double-buffer latch.
- `speed` output 1: SPD bit of the last accepted frame.
- `pwr_down` output 1: PWR bit of the last accepted frame.

## Operation
- **Synchronization:** each input passes through `SYNC_STAGES` flops. Edge detect compares the last synchronizer stage with one further registered copy.
- **Reset values:** synchronizer flops of `DAC_cs_n` and `DAC_sclk` reset to 1. All other flops reset to 0. Every output is 0 in reset.
- **State machine:** states IDLE, SHIFT, COMMIT.
  - IDLE → SHIFT on a detected `DAC_cs_n` fall. This clears `shreg` and `bitcnt`.
  - SHIFT, on a detected `DAC_sclk` fall: `shreg <= {shreg[14:0], din_sync}`. `bitcnt` increments and saturates at 17.
  - SHIFT → COMMIT on a detected `DAC_cs_n` rise.
  - COMMIT → IDLE unconditionally after one cycle.
- **COMMIT, `bitcnt` ≠ 16:** pulse `frame_err`. No other register changes.
- **COMMIT, `bitcnt` = 16:** `word <= shreg` and pulse `word_valid`. Then decode D15=R1, D14=SPD, D13=PWR, D12=R0, D11..0=data:
  - R1R0=00: `dac_b <= data`, `dac_buf <= data`.
  - R1R0=01: `dac_buf <= data`.
  - R1R0=10: `dac_a <= data`, `dac_b <= dac_buf` (old buffer value).
  - R1R0=11: pulse `rsvd_err`. No latch, `speed` or `pwr_down` change.
  - For 00/01/10: `speed <= SPD` and `pwr_down <= PWR`.
- **Ignored activity:** `DAC_sclk` edges in IDLE or COMMIT are ignored. A `DAC_cs_n` fall in COMMIT is ignored.
- **Same-cycle events:** a `DAC_cs_n` rise and `DAC_sclk` fall detected in the same cycle: the rise wins and that bit is not shifted.
- **Reset mid-frame:** `rst_n` low clears all state immediately, including latches. A frame in progress is discarded with no error pulse.

## Timing
- Input-to-detect latency: `SYNC_STAGES`+1 `clk` cycles from a pin edge to its detected edge.
- Data sampling: `din_sync` is taken in the same cycle the `DAC_sclk` fall is detected. `DAC_din` must be stable from `SYNC_STAGES`+1 cycles before the `DAC_sclk` fall until 1 cycle after it.
- Commit timing, relative to the cycle the `DAC_cs_n` rise is detected (cycle N):
  - COMMIT is entered at N+1.
  - `word`, `dac_*`, `speed` and `pwr_down` change at the N+2 rising edge.
  - `word_valid`, `frame_err` and `rsvd_err` are high for exactly cycle N+2.
- Minimum CS-high time between frames: 3 `clk` cycles after the detected rise.
- Back-to-back frames meeting that minimum are all decoded.

## Test plan
- Reset with `rst_n` low and pins idle → all outputs 0. No pulse after release.
- Frame 0x57D0 → `word_valid` pulse, `word`=0x57D0, `dac_buf`=0x7D0, `dac_a`=0, `dac_b`=0, `speed`=1, `pwr_down`=0.
- Next frame 0xC3E8 → `dac_a`=0x3E8, `dac_b`=0x7D0, `dac_buf`=0x7D0 unchanged, `speed`=1.
- Frame 0x2ABC (R1R0=00, PWR=1) → `dac_b`=0xABC, `dac_buf`=0xABC, `pwr_down`=1. Then 0xD123 (R1R0=11) → `rsvd_err` pulse, `word`=0xD123, all latches and `pwr_down` unchanged.
- Frames with 15 and with 17 `DAC_sclk` falls → `frame_err` pulse each time. `word_valid` stays 0 and latches are unchanged. A following good 0x0555 → `dac_b`=0x555.
- `rst_n` asserted after 8 bits of a frame → outputs 0 immediately. After release, a full 0x8FFF frame → `dac_a`=0xFFF, `dac_b`=0x000 (buffer cleared by reset).
